// File: rtl/barrel_shifter.sv
// Registered right-shift alignment unit for the FP adder: shifts {in, guard, round}
// right by shift_amount and collects every bit pushed past the round position into sticky.
module barrel_shifter #(
    parameter int width       = 24,
    parameter int shift_width = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [width-1:0]       in,
    input  logic [shift_width-1:0] shift_amount,
    output logic                   out_valid,
    output logic [width+1:0]       out,
    output logic                   sticky
);

    localparam int ext_width = width + 2;

    logic [ext_width-1:0] stage_val [0:shift_width];
    logic [shift_width:0] stage_sticky;

    assign stage_val[0]    = {in, 2'b00};
    assign stage_sticky[0] = 1'b0;

    // Stage k shifts by 2**k; a stage at least as wide as the operand flushes everything
    // into sticky, which is how oversized shift amounts saturate.
    for (genvar k = 0; k < shift_width; k++) begin : g_stage
        localparam bit flush = (64'd1 << k) >= 64'(ext_width);
        if (flush) begin : g_flush
            assign stage_val[k+1]    = shift_amount[k] ? '0 : stage_val[k];
            assign stage_sticky[k+1] = stage_sticky[k] | (shift_amount[k] & (|stage_val[k]));
        end else begin : g_shift
            localparam int amt = 1 << k;
            assign stage_val[k+1]    = shift_amount[k] ? (stage_val[k] >> amt) : stage_val[k];
            assign stage_sticky[k+1] = stage_sticky[k] | (shift_amount[k] & (|stage_val[k][amt-1:0]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out       <= stage_val[shift_width];
            sticky    <= stage_sticky[shift_width];
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed and randomised checks of barrel_shifter at width=24, shift_width=5.
module tb_barrel_shifter;

    localparam int W  = 24;
    localparam int SW = 5;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  in;
    logic [SW-1:0] shift_amount;
    logic          out_valid;
    logic [W+1:0]  out;
    logic          sticky;

    int errors = 0;
    int checks = 0;

    barrel_shifter #(.width(W), .shift_width(SW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in(in),
        .shift_amount(shift_amount),
        .out_valid(out_valid),
        .out(out),
        .sticky(sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-by-bit reference: a bit of E lands at i-sh if i>=sh, otherwise it feeds sticky.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input int sh);
        logic [W+1:0] e;
        logic [W+1:0] r;
        logic         s;
        e = {a, 2'b00};
        r = '0;
        s = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            if (i >= sh) r[i-sh] = e[i];
            else         s = s | e[i];
        end
        return {r, s};
    endfunction

    // Drives one operation mid-cycle and returns after the capturing edge plus settle time.
    task automatic drive(input logic [W-1:0] a, input int sh, input logic v);
        @(negedge clk);
        in           = a;
        shift_amount = SW'(sh);
        in_valid     = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        in           = 24'hABCDEF;
        shift_amount = 5'd7;
        in_valid     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out, sticky, out_valid} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_hold: out=%h sticky=%b valid=%b, want all 0", out, sticky, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(24'h123456, 0, 1'b1);
        checks++;
        if (out !== {24'h123456, 2'b00} || sticky !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_first: out=%h sticky=%b valid=%b, want %h 0 1",
                     out, sticky, out_valid, {24'h123456, 2'b00});
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] vin  [12] = '{24'h123456, 24'h123456, 24'h123456, 24'h123456, 24'h123456,
                                    24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                                    24'h800000, 24'h800000, 24'h000000};
        int           vsh  [12] = '{1, 10, 24, 25, 30, 3, 24, 25, 31, 23, 24, 31};
        logic [W-1:0] vmag [12] = '{24'h091A2B, 24'h00048D, 24'h0, 24'h0, 24'h0,
                                    24'h1FFFFF, 24'h0, 24'h0, 24'h0,
                                    24'h000001, 24'h0, 24'h0};
        logic [1:0]   vgr  [12] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                    2'b11, 2'b11, 2'b01, 2'b00,
                                    2'b00, 2'b10, 2'b00};
        logic         vst  [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b1, 1'b1, 1'b1, 1'b1,
                                    1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            drive(vin[i], vsh[i], 1'b1);
            checks++;
            if (out !== {vmag[i], vgr[i]} || sticky !== vst[i] || out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL directed_%0d in=%h sh=%0d: out=%h sticky=%b valid=%b, want out=%h sticky=%b valid=1",
                         i, vin[i], vsh[i], out, sticky, out_valid, {vmag[i], vgr[i]}, vst[i]);
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        logic [W-1:0] a;
        int           sh;
        logic         v;
        logic [W+2:0] exp;
        for (int i = 0; i < n; i++) begin
            a  = W'($urandom);
            sh = int'($urandom_range(0, 31));
            v  = 1'($urandom);
            exp = model(a, sh);
            drive(a, sh, v);
            checks++;
            if ({out, sticky} !== exp || out_valid !== v) begin
                errors++;
                $display("[TB] FAIL stream_%0d in=%h sh=%0d: out=%h sticky=%b valid=%b, want out=%h sticky=%b valid=%b",
                         i, a, sh, out, sticky, out_valid, exp[W+2:1], exp[0], v);
            end
        end
    endtask

    task automatic test_mid_reset;
        drive(24'hFFFFFF, 3, 1'b1);
        @(negedge clk);
        in           = 24'h7FFFFF;
        shift_amount = 5'd2;
        in_valid     = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out, sticky, out_valid} !== '0) begin
            errors++;
            $display("[TB] FAIL async_clear: out=%h sticky=%b valid=%b, want all 0", out, sticky, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out, sticky, out_valid} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_discard: out=%h sticky=%b valid=%b, want all 0", out, sticky, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_back_to_back(20);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back(200);
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Registered right-shift alignment unit for the floating-point adder datapath.
- Shifts the smaller operand's significand right by the exponent difference.
- Appends a guard bit and a round bit below the LSB.
- Produces a sticky bit: the OR of every bit shifted beyond the round position.
- Result is presented one clock after the inputs are sampled.

Parameters:
- width, 24, significand width in bits (hidden bit included); must be >= 2.
- shift_width, 5, width of the shift-amount field. 2**shift_width may be smaller than, equal to, or larger than width+2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies in and shift_amount for this cycle.
- in  input  width  unsigned significand to be aligned.
- shift_amount  input  shift_width  unsigned right-shift distance, 0 to 2**shift_width-1.
- out_valid  output  1  registered copy of in_valid.
- out  output  width+2  out[width+1:2] is the shifted significand, out[1] is guard, out[0] is round.
- sticky  output  1  OR of all bits of the extended operand shifted below out[0].

Behaviour:
- Extended operand: E = {in, 2'b00}, width+2 bits. Next result R = E >> shift_amount, a logical shift with zeros entering at the MSB.
- Next sticky S = 1 when any bit of E at index < shift_amount is 1, otherwise 0. For shift_amount = 0, S = 0.
- Saturation: if shift_amount >= width+2, then R = 0 and S = |in.
  - When shift_amount = width or width+1, part of in still lands in the guard/round bits.
- Implementation: log2 staged mux network, one stage per shift_amount bit (shift by 2**k when bit k is set).
  - Each stage ORs its discarded bits into a running sticky.
  - A single fully combinational shift followed by a masked OR is equally acceptable if timing allows.
  - No iterative or multi-cycle shifting.
- Latency: exactly 1 cycle. On each rising clk edge:
  - out <= R
  - sticky <= S
  - out_valid <= in_valid
- Throughput: one new operation per cycle; no backpressure.
- Data registers load every cycle regardless of in_valid. Downstream logic qualifies the data with out_valid.
- Reset: while rst_n = 0, out = 0, sticky = 0, out_valid = 0, immediately and without waiting for clk. This includes reset asserted mid-operation, which discards the in-flight result.
- On rst_n deassertion, the first capture happens at the next rising clk edge.
- Outputs must not contain X when inputs are known. Unused high shift_amount bits are handled by the saturation rule, not left undefined.
- No internal state beyond the output registers.

Test Plan (width=24, shift_width=5; each check is on outputs one cycle after applying the inputs with in_valid=1):
- Reset: hold rst_n=0 with arbitrary inputs and clk toggling -> out=0, sticky=0, out_valid=0. Release reset, apply in=0x123456, shift_amount=0 -> out[25:2]=0x123456, out[1:0]=00, sticky=0, out_valid=1.
- in=0x123456, shift 1 -> out[25:2]=0x091A2B, GR=00, sticky=0. Shift 10 -> out[25:2]=0x00048D, GR=00, sticky=1.
- in=0x123456, shift 24 -> out[25:2]=0x000000, GR=00, sticky=1. Shift 25 -> 0x000000, GR=00, sticky=1. Shift 30 (saturation) -> 0x000000, GR=00, sticky=1.
- in=0xFFFFFF, shift 3 -> out[25:2]=0x1FFFFF, GR=11, sticky=1. Shift 24 -> 0x000000, GR=11, sticky=1. Shift 25 -> GR=01, sticky=1. Shift 31 -> all zero, sticky=1.
- in=0x800000: shift 23 -> out[25:2]=0x000001, GR=00, sticky=0; shift 24 -> GR=10, sticky=0. in=0x000000 with shift 31 -> all zero, sticky=0.
- Pipelining: change inputs every cycle with random in/shift_amount and random in_valid; compare against a reference model delayed one cycle. Assert rst_n mid-stream -> outputs clear asynchronously and resume correctly afterwards.
